// File: rtl/game_ctrl.sv
// game_ctrl: tic-tac-toe move/turn/winner controller driving per-cell square drawers.
// Optional macro FRAME_SYNC_EN: square_x/square_o become vsync-aligned shadow registers.
`default_nettype none

module game_ctrl (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_cell,
  output logic       move_ready,
  output logic       move_reject,
  input  logic       vsync_in,
  output logic [8:0] square_x,
  output logic [8:0] square_o,
  output logic       turn,
  output logic [1:0] winner,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, WAIT_MOVE, CHECK, OVER} state_t;

  state_t     state_q, state_d;
  logic [8:0] bx_q, bx_d, bo_q, bo_d;
  logic       turn_q, turn_d;
  logic [1:0] winner_q, winner_d;
  logic       over_q, over_d;
  logic       reject_q, reject_d;

  logic       hs;
  logic       cell_legal;
  logic [8:0] cell_mask;

  function automatic logic has_line(input logic [8:0] b);
    return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  assign move_ready  = (state_q == WAIT_MOVE);
  assign move_reject = reject_q;
  assign turn        = turn_q;
  assign winner      = winner_q;
  assign game_over   = over_q;

  // new_game wins over a simultaneous move, so it also masks the handshake.
  assign hs         = move_valid & move_ready & ~new_game;
  assign cell_mask  = 9'd1 << move_cell;
  assign cell_legal = (move_cell <= 4'd8) && ((cell_mask & (bx_q | bo_q)) == 9'd0);

  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    bo_d     = bo_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    over_d   = over_q;
    reject_d = 1'b0;
    if (new_game) begin
      state_d  = WAIT_MOVE;
      bx_d     = 9'd0;
      bo_d     = 9'd0;
      turn_d   = 1'b0;
      winner_d = 2'b00;
      over_d   = 1'b0;
    end else begin
      case (state_q)
        WAIT_MOVE: begin
          if (hs) begin
            if (cell_legal) begin
              if (turn_q) bo_d = bo_q | cell_mask;
              else        bx_d = bx_q | cell_mask;
              state_d = CHECK;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (has_line(turn_q ? bo_q : bx_q)) begin
            winner_d = turn_q ? 2'b10 : 2'b01;
            over_d   = 1'b1;
            state_d  = OVER;
          end else if (&(bx_q | bo_q)) begin
            winner_d = 2'b11;
            over_d   = 1'b1;
            state_d  = OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = WAIT_MOVE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bx_q     <= 9'd0;
      bo_q     <= 9'd0;
      turn_q   <= 1'b0;
      winner_q <= 2'b00;
      over_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bx_q     <= bx_d;
      bo_q     <= bo_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      over_q   <= over_d;
      reject_q <= reject_d;
    end
  end

`ifdef FRAME_SYNC_EN
  logic       vsync_q;
  logic [8:0] sx_q, so_q;

  // Shadows follow the board only on the edge that first sees vsync high,
  // so the display never changes mid-frame.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      sx_q    <= 9'd0;
      so_q    <= 9'd0;
    end else begin
      vsync_q <= vsync_in;
      if (new_game) begin
        sx_q <= 9'd0;
        so_q <= 9'd0;
      end else if (vsync_in && !vsync_q) begin
        sx_q <= bx_q;
        so_q <= bo_q;
      end
    end
  end

  assign square_x = sx_q;
  assign square_o = so_q;
`else
  logic unused_vsync;
  assign unused_vsync = vsync_in;
  assign square_x     = bx_q;
  assign square_o     = bo_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed scenario bench for game_ctrl with hand-computed expectations.
`default_nettype none

module tb_game_ctrl;

  logic       pclk, rst_n, new_game, move_valid, vsync_in;
  logic [3:0] move_cell;
  logic       move_ready, move_reject, turn, game_over;
  logic [8:0] square_x, square_o;
  logic [1:0] winner;

  int n_checks = 0;
  int n_fail   = 0;

  game_ctrl dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_cell  (move_cell),
    .move_ready (move_ready),
    .move_reject(move_reject),
    .vsync_in   (vsync_in),
    .square_x   (square_x),
    .square_o   (square_o),
    .turn       (turn),
    .winner     (winner),
    .game_over  (game_over)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic pulse_new_game;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  // Waits for move_ready, handshakes one move, returns after the evaluation edge.
  task automatic play(input logic [3:0] c);
    int n;
    n = 0;
    while (!move_ready && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= 20) begin
      n_fail++;
      $display("FAIL play_ready_timeout: move_ready=%b required 1 within 20 cycles", move_ready);
    end
    move_valid = 1'b1;
    move_cell  = c;
    tick();
    move_valid = 1'b0;
    tick();
  endtask

  // Only meaningful when the squares are vsync shadows; a no-op otherwise.
  task automatic sync_frame;
`ifdef FRAME_SYNC_EN
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    tick();
`endif
  endtask

  task automatic test_reset;
    n_checks++; if ({square_x, square_o} !== 18'd0) begin n_fail++; $display("FAIL reset_squares: got %h/%h required 0/0", square_x, square_o); end
    n_checks++; if ({turn, winner, game_over} !== 4'd0) begin n_fail++; $display("FAIL reset_status: turn/winner/over got %b/%b/%b required 0/00/0", turn, winner, game_over); end
    n_checks++; if ({move_ready, move_reject} !== 2'b00) begin n_fail++; $display("FAIL reset_handshake: ready/reject got %b/%b required 0/0", move_ready, move_reject); end
    @(posedge pclk); #1;
    rst_n = 1'b1;
    move_valid = 1'b1;
    move_cell  = 4'd0;
    tick(); tick(); tick();
    move_valid = 1'b0;
    n_checks++; if (move_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b required 0", move_ready); end
    n_checks++; if (move_reject !== 1'b0 || square_x !== 9'd0) begin n_fail++; $display("FAIL idle_ignores_move: reject/square_x got %b/%h required 0/000", move_reject, square_x); end
  endtask

  task automatic test_latency;
    pulse_new_game();
    n_checks++; if (move_ready !== 1'b1) begin n_fail++; $display("FAIL newgame_ready: got %b required 1", move_ready); end
    move_valid = 1'b1;
    move_cell  = 4'd0;
    tick();
    move_valid = 1'b0;
    n_checks++; if (move_ready !== 1'b0 || turn !== 1'b0) begin n_fail++; $display("FAIL check_cycle: ready/turn got %b/%b required 0/0", move_ready, turn); end
`ifndef FRAME_SYNC_EN
    n_checks++; if (square_x !== 9'h001) begin n_fail++; $display("FAIL board_n1: square_x got %h required 001", square_x); end
`endif
    tick();
    n_checks++; if (move_ready !== 1'b1 || turn !== 1'b1 || winner !== 2'b00) begin n_fail++; $display("FAIL after_check: ready/turn/winner got %b/%b/%b required 1/1/00", move_ready, turn, winner); end
  endtask

  task automatic test_x_wins_row;
    pulse_new_game();
    play(4'd0); play(4'd3); play(4'd1); play(4'd4); play(4'd2);
    sync_frame();
    n_checks++; if (square_x !== 9'h007 || square_o !== 9'h018) begin n_fail++; $display("FAIL xwin_board: got %h/%h required 007/018", square_x, square_o); end
    n_checks++; if (winner !== 2'b01 || game_over !== 1'b1 || turn !== 1'b0) begin n_fail++; $display("FAIL xwin_status: winner/over/turn got %b/%b/%b required 01/1/0", winner, game_over, turn); end
    n_checks++; if (move_ready !== 1'b0) begin n_fail++; $display("FAIL over_ready: got %b required 0", move_ready); end
    move_valid = 1'b1;
    move_cell  = 4'd5;
    tick();
    move_valid = 1'b0;
    n_checks++; if (move_reject !== 1'b0) begin n_fail++; $display("FAIL over_no_reject: got %b required 0", move_reject); end
    tick();
    sync_frame();
    n_checks++; if (square_o !== 9'h018 || game_over !== 1'b1) begin n_fail++; $display("FAIL over_held: square_o/over got %h/%b required 018/1", square_o, game_over); end
  endtask

  task automatic test_occupied;
    pulse_new_game();
    play(4'd4);
    move_valid = 1'b1;
    move_cell  = 4'd4;
    tick();
    move_valid = 1'b0;
    n_checks++; if (move_reject !== 1'b1) begin n_fail++; $display("FAIL occupied_reject: got %b required 1", move_reject); end
    tick();
    n_checks++; if (move_reject !== 1'b0) begin n_fail++; $display("FAIL occupied_single_pulse: got %b required 0", move_reject); end
    n_checks++; if (square_o !== 9'd0 || turn !== 1'b1 || move_ready !== 1'b1) begin n_fail++; $display("FAIL occupied_state: square_o/turn/ready got %h/%b/%b required 000/1/1", square_o, turn, move_ready); end
    play(4'd5);
    sync_frame();
    n_checks++; if (square_o !== 9'h020 || turn !== 1'b0) begin n_fail++; $display("FAIL occupied_then_accept: square_o/turn got %h/%b required 020/0", square_o, turn); end
  endtask

  task automatic test_illegal_cell;
    pulse_new_game();
    move_valid = 1'b1;
    move_cell  = 4'd12;
    tick();
    move_valid = 1'b0;
    n_checks++; if (move_reject !== 1'b1) begin n_fail++; $display("FAIL illegal_reject: got %b required 1", move_reject); end
    n_checks++; if (square_x !== 9'd0 || square_o !== 9'd0 || turn !== 1'b0) begin n_fail++; $display("FAIL illegal_state: got %h/%h/%b required 000/000/0", square_x, square_o, turn); end
    tick();
    n_checks++; if (move_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready: got %b required 1", move_ready); end
  endtask

  task automatic test_draw;
    pulse_new_game();
    play(4'd0); play(4'd1); play(4'd2); play(4'd4); play(4'd3);
    play(4'd5); play(4'd7); play(4'd6); play(4'd8);
    sync_frame();
    n_checks++; if (winner !== 2'b11 || game_over !== 1'b1) begin n_fail++; $display("FAIL draw_status: winner/over got %b/%b required 11/1", winner, game_over); end
    n_checks++; if ((square_x | square_o) !== 9'h1FF || square_x !== 9'h18D) begin n_fail++; $display("FAIL draw_board: got %h/%h required 18D/072", square_x, square_o); end
  endtask

  task automatic test_new_game_priority;
    pulse_new_game();
    play(4'd0);
    new_game   = 1'b1;
    move_valid = 1'b1;
    move_cell  = 4'd4;
    tick();
    new_game   = 1'b0;
    move_valid = 1'b0;
    n_checks++; if (turn !== 1'b0 || move_ready !== 1'b1 || move_reject !== 1'b0) begin n_fail++; $display("FAIL ng_prio_state: turn/ready/reject got %b/%b/%b required 0/1/0", turn, move_ready, move_reject); end
    sync_frame();
    n_checks++; if (square_x !== 9'd0 || square_o !== 9'd0) begin n_fail++; $display("FAIL ng_prio_board: got %h/%h required 000/000", square_x, square_o); end
  endtask

  task automatic test_back_to_back;
    pulse_new_game();
    move_valid = 1'b1;
    move_cell  = 4'd0;
    tick();
    move_cell  = 4'd4;
    tick();
    tick();
    move_valid = 1'b0;
    tick();
    sync_frame();
    n_checks++; if (square_x !== 9'h001 || square_o !== 9'h010) begin n_fail++; $display("FAIL b2b_board: got %h/%h required 001/010", square_x, square_o); end
    n_checks++; if (turn !== 1'b0 || move_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_state: turn/ready got %b/%b required 0/1", turn, move_ready); end
  endtask

  task automatic test_async_reset;
    pulse_new_game();
    play(4'd0); play(4'd1); play(4'd2);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({square_x, square_o, turn, winner, game_over, move_ready, move_reject} !== 24'd0) begin n_fail++; $display("FAIL async_reset: x/o/turn/winner/over/ready got %h/%h/%b/%b/%b/%b required all 0", square_x, square_o, turn, winner, game_over, move_ready); end
    @(posedge pclk); #1;
    rst_n = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (move_ready !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: ready got %b required 0", move_ready); end
    pulse_new_game();
    n_checks++; if (move_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_newgame: ready got %b required 1", move_ready); end
  endtask

`ifdef FRAME_SYNC_EN
  task automatic test_frame_sync;
    pulse_new_game();
    play(4'd0);
    tick();
    n_checks++; if (square_x !== 9'd0) begin n_fail++; $display("FAIL fsync_hold: square_x got %h required 000", square_x); end
    vsync_in = 1'b1;
    #2;
    n_checks++; if (square_x !== 9'd0) begin n_fail++; $display("FAIL fsync_pre_edge: square_x got %h required 000", square_x); end
    tick();
    vsync_in = 1'b0;
    n_checks++; if (square_x !== 9'h001) begin n_fail++; $display("FAIL fsync_load: square_x got %h required 001", square_x); end
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    new_game   = 1'b0;
    move_valid = 1'b0;
    move_cell  = 4'd0;
    vsync_in   = 1'b0;
    #12;
    test_reset();
    test_latency();
    test_x_wins_row();
    test_occupied();
    test_illegal_cell();
    test_draw();
    test_new_game_priority();
    test_back_to_back();
    test_async_reset();
`ifdef FRAME_SYNC_EN
    test_frame_sync();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports declared as follows:
- pclk  input  1  pixel clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
REQ-002 new_game  input  1  single-cycle pulse; clears the board and starts a game.
REQ-003 move_valid  input  1  a move request is presented.
REQ-004 move_cell  input  4  target cell, 0..8 row-major (0 = top-left); values 9..15 are illegal.
REQ-005 move_ready  output  1  the block can accept a move this cycle.
REQ-006 move_reject  output  1  single-cycle pulse; the last handshaked move was refused.
REQ-007 vsync_in  input  1  vertical sync from the timing chain; used only when FRAME_SYNC_EN is defined.
REQ-008 square_x  output  9  bit i = cell i holds X; drives the per-cell square drawers.
REQ-009 square_o  output  9  bit i = cell i holds O.
REQ-010 turn  output  1  0 = X to move, 1 = O to move.
REQ-011 winner  output  2  00 none, 01 X, 10 O, 11 draw.
REQ-012 game_over  output  1  high while the game has ended.

Function
REQ-013 The FSM SHALL have four states: IDLE, WAIT_MOVE, CHECK, OVER.
REQ-014 IDLE: move_ready = 0; new_game moves to WAIT_MOVE with an empty board and turn = 0.
REQ-015 WAIT_MOVE: move_ready = 1; a handshake occurs when move_valid and move_ready are both high.
REQ-016 Legal handshake (cell <= 8 and cell empty): at the next edge the cell bit is set in the board of the current player and the FSM enters CHECK.
REQ-017 Illegal handshake (cell >= 9 or cell already occupied): the board is unchanged, move_reject pulses the next cycle, and the FSM stays in WAIT_MOVE.
REQ-018 CHECK: move_ready = 0 for exactly one cycle while the board is evaluated against 8 lines (3 rows, 3 columns, 2 diagonals) for the player who just moved.
REQ-019 CHECK outcome, win: winner = 01 or 10, game_over = 1, FSM enters OVER; turn is not toggled.
REQ-020 CHECK outcome, no win with all 9 cells occupied: winner = 11, game_over = 1, FSM enters OVER.
REQ-021 CHECK outcome, otherwise: turn toggles and the FSM returns to WAIT_MOVE.
REQ-022 Latency: a handshake in cycle N updates the internal board at N+1 and winner/game_over/turn at N+2; move_ready returns high at N+2 if play continues.
REQ-023 OVER: move_ready = 0; moves are ignored with no reject pulse; the board is held.
REQ-024 new_game SHALL take priority over any simultaneous move in every state: it clears both boards, sets turn = 0, winner = 00, game_over = 0, and enters WAIT_MOVE.
REQ-025 move_valid held high across a handshake SHALL be treated as a new request at the next move_ready.

Reset
REQ-026 While rst_n = 0, the outputs and state SHALL be held at reset values:
- square_x = 0, square_o = 0
- turn = 0, winner = 00, game_over = 0
- move_ready = 0, move_reject = 0
- FSM in IDLE
REQ-027 Reset assertion mid-game SHALL discard the board immediately, without waiting for a clock edge.
REQ-028 After deassertion, the block SHALL stay in IDLE until new_game.

Configuration
REQ-029 The macro FRAME_SYNC_EN SHALL select how square_x and square_o are updated.
REQ-030 With FRAME_SYNC_EN defined, square_x and square_o SHALL be shadow registers loaded from the internal board only on the cycle after a rising edge of vsync_in; the internal board and winner are unaffected.
REQ-031 With FRAME_SYNC_EN defined, a new_game pulse SHALL clear the shadow registers on the same edge as the internal board.
REQ-032 Without FRAME_SYNC_EN, square_x and square_o SHALL equal the internal board registers directly, with no vsync dependency.

Verification
REQ-033 Scenario, X wins a row: reset, new_game, then moves 0,3,1,4,2 -> square_x = 0x007, square_o = 0x018, winner = 01, game_over = 1, turn = 0.
REQ-034 Scenario, occupied-cell rejection: new_game, move 4, then move 4 again -> move_reject pulses once, square_o = 0, turn = 1, FSM still accepts a move.
REQ-035 Scenario, illegal cell: new_game, move_cell = 12 -> reject pulse, board = 0, turn = 0.
REQ-036 Scenario, draw: moves 0,1,2,4,3,5,7,6,8 -> winner = 11, game_over = 1, square_x | square_o = 0x1FF.
REQ-037 Scenario, async reset: assert rst_n low between clock edges after 3 moves -> all outputs 0 before the next pclk edge; IDLE persists until new_game.
REQ-038 Scenario, frame sync (FRAME_SYNC_EN defined): legal move 0 with no vsync edge -> square_x = 0; after a vsync_in rising edge -> square_x = 0x001 one cycle later.
